// File: rtl/region_rmw_sequencer.sv
// Raster-order read-modify-write walker over a WxH image region, one pixel per 3+RD_LAT cycles.
// Backpressure: holds PROC while pe_ready is low. Optional stall counter under RMW_PERF_CNT_EN.
module region_rmw_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DIM_W  = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pe_valid,
  output logic [DATA_W-1:0] pe_pixel,
  output logic [DIM_W-1:0]  pe_x,
  output logic [DIM_W-1:0]  pe_y,
  input  logic              pe_ready,
  input  logic [DATA_W-1:0] pe_result
`ifdef RMW_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_PROC, S_WRITE, S_DONE
  } state_t;

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIM_W-1:0]  r_width;
  logic [DIM_W-1:0]  r_height;
  logic [DIM_W-1:0]  r_x;
  logic [DIM_W-1:0]  r_y;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_pixel;
  logic [DATA_W-1:0] r_result;
  logic [CNT_W-1:0]  r_wait_cnt;

  logic w_accept;
  logic w_last_wait;
  logic w_last_x;
  logic w_last_pix;

  assign w_accept    = (r_state == S_IDLE) && start && !abort;
  assign w_last_wait = (r_wait_cnt == CNT_W'(RD_LAT - 1));
  assign w_last_x    = (r_x == r_width - DIM_W'(1));
  assign w_last_pix  = w_last_x && (r_y == r_height - DIM_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = ((width == '0) || (height == '0)) ? S_DONE : S_READ;
      S_READ:  w_state_nxt = S_WAIT;
      S_WAIT:  if (w_last_wait) w_state_nxt = S_PROC;
      S_PROC:  if (pe_ready) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = w_last_pix ? S_DONE : S_READ;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // abort beats every transition, including WRITE->DONE
    if (abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_width    <= '0;
      r_height   <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_cur_addr <= '0;
      r_mem_addr <= '0;
      r_pixel    <= '0;
      r_result   <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_width    <= width;
          r_height   <= height;
          r_x        <= '0;
          r_y        <= '0;
          r_cur_addr <= base_addr;
        end
        S_READ: begin
          r_mem_addr <= r_cur_addr;
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (w_last_wait) r_pixel <= mem_rdata;
        end
        S_PROC: if (pe_ready) r_result <= pe_result;
        S_WRITE: if (!abort) begin
          r_mem_addr <= r_cur_addr;
          r_cur_addr <= r_cur_addr + ADDR_W'(1);
          // coordinates stay on the last pixel once the run finishes
          if (!w_last_pix) begin
            if (w_last_x) begin
              r_x <= '0;
              r_y <= r_y + DIM_W'(1);
            end else begin
              r_x <= r_x + DIM_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE) && !abort;
  assign mem_we    = (r_state == S_WRITE) && !abort;
  assign mem_addr  = ((r_state == S_READ) || (r_state == S_WRITE)) ? r_cur_addr : r_mem_addr;
  assign mem_wdata = r_result;
  assign pe_valid  = (r_state == S_PROC);
  assign pe_pixel  = r_pixel;
  assign pe_x      = r_x;
  assign pe_y      = r_y;

`ifdef RMW_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_accept) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_PROC) && !pe_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule
